msk_xor_acc: RTL and testbench
==============================

Name: msk_xor_acc

Overview:
- Streaming masked XOR accumulator for the masked AES datapath.
- Takes a sequence of d-share sharings of count-bit words and outputs their share-wise XOR as a single sharing. This covers AddRoundKey chains and MixColumns column sums.
- valid/ready on input and output.
- Sits between share-domain datapath stages. It never recombines shares.

Parameters:
- d, 2, number of shares (>=2).
- count, 8, number of shared bits per operand.
- MAX_OPS, 4, maximum operands per accumulation (>=2); the accumulation auto-terminates at this count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  operand available.
- in_ready  output  1  operand accepted when in_valid and in_ready are both high.
- in_data  input  count*d  operand sharing; bit j, share i at index j*d+i.
- in_last  input  1  qualifies in_data as the final operand of the accumulation.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts the result.
- out_data  output  count*d  accumulated sharing, same layout as in_data.
- out_nops  output  $clog2(MAX_OPS+1)  number of operands folded into out_data.
- rnd  input  count*(d-1)  fresh randomness; present only with MSK_XOR_ACC_REFRESH_EN.

Behaviour:
- State: acc (count*d), nops counter, FSM {IDLE, ACCUM, HOLD}.
- Reset (asynchronous, immediate): acc=0, nops=0, state=IDLE, out_valid=0, out_data=0, out_nops=0.
- Reset mid-accumulation discards the partial result; no output is produced for it.
- in_ready:
  - 1 in IDLE and ACCUM.
  - In HOLD, in_ready = out_ready, so an output handshake and a new first operand can complete in the same cycle.
- Input handshake in IDLE, or in HOLD with an output handshake in the same cycle:
  - acc <= in_data, nops <= 1.
  - Next state is ACCUM, or HOLD if in_last.
- Input handshake in ACCUM:
  - acc <= acc ^ in_data, share-wise, no cross-share mixing.
  - nops <= nops+1.
  - Go to HOLD if in_last or nops+1 == MAX_OPS; otherwise stay in ACCUM.
- A single-operand accumulation (in_last on the first operand) is legal; the result equals the operand.
- Completion on MAX_OPS ignores in_last; the next operand starts a new accumulation.
- HOLD:
  - out_valid=1; out_data=acc and out_nops=nops, both stable until the handshake.
  - Output handshake without an input handshake: go to IDLE, out_valid=0.
- Latency: out_valid rises one cycle after the handshake of the final operand.
- Throughput: one operand per cycle. Back-to-back accumulations have no bubble when out_ready is held high.
- XOR operations are instantiated per share bit through the team's masked XOR gate (keep_hierarchy), so synthesis cannot merge shares.
- out_data is driven only from registers. No combinational path from in_data to out_data.

Optional Feature:
- Macro: MSK_XOR_ACC_REFRESH_EN.
- Defined:
  - The rnd port exists.
  - On the cycle that enters HOLD, for every bit j the register captures refreshed shares:
    - share i ^= rnd[j*(d-1)+i] for i<d-2+1.
    - share d-1 ^= XOR of all rnd bits for bit j.
  - The unmasked value is unchanged.
  - rnd is sampled only on that cycle.
- Undefined: no rnd port; the final value is stored unrefreshed.
- Latency is identical in both builds.

Decomposition:
- Package msk_acc_pkg:
  - share-index function idx(bit, share) = bit*d+share.
  - state enum {IDLE, ACCUM, HOLD}.
  - nops width function.
- Sub-module msk_refresh (d, count):
  - Combinational refresh gadget used only under MSK_XOR_ACC_REFRESH_EN.
  - keep_hierarchy.

Test Plan:
- d=2, count=8, MAX_OPS=4. Feed sharings of 0x3C, 0xA5, 0x0F with in_last on the third; out_ready=1 -> one cycle later out_valid=1, unmasked out_data=0x96, out_nops=3.
- Feed 4 operands 0x01, 0x02, 0x04, 0x08 with in_last never asserted -> auto-termination; unmasked 0x0F, out_nops=4. The fifth operand starts a new accumulation.
- Hold out_ready=0 for 5 cycles in HOLD -> in_ready=0, out_data stable. Then out_ready=1 together with a new operand 0x77 marked in_last -> both handshakes occur; next result is 0x77 with out_nops=1.
- Pulse rst_n low after 2 of 3 operands -> out_valid=0, out_data=0, out_nops=0 immediately. Post-reset accumulation of 0x11, 0x22 gives 0x33.
- With MSK_XOR_ACC_REFRESH_EN, rnd=0xFF, single operand 0x5A -> unmasked value 0x5A. Share 0 differs from the input share 0 in all 8 bits.
- Random streams, d=3, count=16, random valid/ready stalls, 10k accumulations -> recombined results match the golden XOR model; no per-share cross-mixing in the gate-level netlist check.

Source files
------------

// File: rtl/msk_acc_pkg.sv
// Shared types and helpers for the masked XOR accumulator.
package msk_acc_pkg;

    // Accumulator control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Flat bit position of share s of bit b in a d-share sharing
    function automatic int unsigned idx(input int unsigned b, input int unsigned s,
                                        input int unsigned nd);
        return b * nd + s;
    endfunction

    // Width of a counter able to hold 0..max_ops
    function automatic int unsigned nops_w(input int unsigned max_ops);
        return $clog2(max_ops + 1);
    endfunction

endpackage

// File: rtl/msk_refresh.sv
// Combinational share refresh: re-randomises a sharing without changing its unmasked value.
(* keep_hierarchy = "yes" *)
module msk_refresh
    import msk_acc_pkg::*;
#(
    parameter int unsigned d     = 2,
    parameter int unsigned count = 8
) (
    input  logic [count*d-1:0]     x,
    input  logic [count*(d-1)-1:0] rnd,
    output logic [count*d-1:0]     y
);

    for (genvar j = 0; j < int'(count); j++) begin : g_bit
        logic [d-2:0] r;

        // Randomness slice for this bit
        assign r = rnd[j*(d-1) +: (d-1)];

        for (genvar i = 0; i < int'(d) - 1; i++) begin : g_share
            assign y[idx(j, i, d)] = x[idx(j, i, d)] ^ r[i];
        end

        // Last share absorbs the XOR of all masks so the unmasked bit is preserved
        assign y[idx(j, d - 1, d)] = x[idx(j, d - 1, d)] ^ (^r);
    end

endmodule

// File: rtl/msk_xor.sv
// Single-bit masked XOR gate; kept as its own hierarchy so shares are never merged.
(* keep_hierarchy = "yes" *)
module msk_xor (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/msk_xor_acc.sv
// Streaming masked XOR accumulator: folds a sequence of d-share operands into one sharing.
// Optional feature: define MSK_XOR_ACC_REFRESH_EN to refresh the result as it enters HOLD.
module msk_xor_acc
    import msk_acc_pkg::*;
#(
    parameter int unsigned d       = 2,
    parameter int unsigned count   = 8,
    parameter int unsigned MAX_OPS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [count*d-1:0]           in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [count*d-1:0]           out_data,
    output logic [nops_w(MAX_OPS)-1:0]   out_nops
`ifdef MSK_XOR_ACC_REFRESH_EN
    ,
    input  logic [count*(d-1)-1:0]       rnd
`endif
);

    localparam int unsigned W  = count * d;
    localparam int unsigned NW = nops_w(MAX_OPS);

    state_t        state;
    logic [W-1:0]  acc;
    logic [NW-1:0] nops;

    logic [W-1:0]  xor_c;
    logic [W-1:0]  fold_c;
    logic [W-1:0]  store_c;
    logic [NW-1:0] nops_inc_c;
    logic          in_hs_c;
    logic          start_c;
    logic          add_c;
    logic          done_c;

    // Share-wise XOR of accumulator and operand, one masked gate per share bit
    for (genvar k = 0; k < int'(W); k++) begin : g_xor
        msk_xor u_xor (
            .a (acc[k]),
            .b (in_data[k]),
            .y (xor_c[k])
        );
    end

    // In HOLD a new operand may only enter when the held result leaves in the same cycle
    assign in_ready   = (state != HOLD) | out_ready;
    assign in_hs_c    = in_valid & in_ready;
    assign start_c    = in_hs_c & (state != ACCUM);
    assign add_c      = in_hs_c & (state == ACCUM);
    assign nops_inc_c = nops + NW'(1);

    // Accumulation completes on in_last or when the operand budget is exhausted
    assign done_c = start_c ? in_last
                            : (add_c & (in_last | (nops_inc_c == NW'(MAX_OPS))));

    assign fold_c = start_c ? in_data : xor_c;

`ifdef MSK_XOR_ACC_REFRESH_EN
    logic [W-1:0] fresh_c;

    msk_refresh #(
        .d     (d),
        .count (count)
    ) u_refresh (
        .x   (fold_c),
        .rnd (rnd),
        .y   (fresh_c)
    );

    // Only the value entering HOLD is refreshed, so rnd is consumed on that cycle alone
    assign store_c = done_c ? fresh_c : fold_c;
`else
    assign store_c = fold_c;
`endif

    // Control FSM with accumulator, operand counter and registered output valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            nops      <= '0;
            out_valid <= 1'b0;
        end else begin
            if (start_c || add_c) begin
                acc       <= store_c;
                nops      <= start_c ? NW'(1) : nops_inc_c;
                state     <= done_c ? HOLD : ACCUM;
                out_valid <= done_c;
            end else if ((state == HOLD) && out_ready) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end

    // Result and count come straight from registers
    assign out_data = acc;
    assign out_nops = nops;

endmodule

// File: tb/tb_msk_xor_acc.sv
// Directed bench for msk_xor_acc with d=2, count=8, MAX_OPS=4.
module tb_msk_xor_acc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_nops;
`ifdef MSK_XOR_ACC_REFRESH_EN
    logic [7:0]  rnd;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_data;

    msk_xor_acc #(
        .d       (2),
        .count   (8),
        .MAX_OPS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nops  (out_nops)
`ifdef MSK_XOR_ACC_REFRESH_EN
        ,
        .rnd       (rnd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-share sharing of v with mask m: share0 = m, share1 = v ^ m
    function automatic logic [15:0] share(input logic [7:0] v, input logic [7:0] m);
        logic [15:0] s;
        for (int j = 0; j < 8; j++) begin
            s[2*j]   = m[j];
            s[2*j+1] = v[j] ^ m[j];
        end
        return s;
    endfunction

    function automatic logic [7:0] unmask(input logic [15:0] s);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = s[2*j] ^ s[2*j+1];
        return v;
    endfunction

    function automatic logic [7:0] share0(input logic [15:0] s);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = s[2*j];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and let one rising edge pass
    task automatic drive(input logic [7:0] v, input logic [7:0] m, input logic last);
        in_valid = 1'b1;
        in_data  = share(v, m);
        in_last  = last;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
`ifdef MSK_XOR_ACC_REFRESH_EN
        rnd       = '0;
`endif
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_nops",  32'(out_nops),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three operands closed by in_last
        drive(8'h3C, 8'h5E, 1'b0);
        chk("t1_mid_valid", 32'(out_valid), 32'd0);
        drive(8'hA5, 8'h19, 1'b0);
        drive(8'h0F, 8'hC7, 1'b1);
        in_valid = 1'b0;
        exp_data = share(8'h3C, 8'h5E) ^ share(8'hA5, 8'h19) ^ share(8'h0F, 8'hC7);
        chk("t1_valid",  32'(out_valid),        32'd1);
        chk("t1_value",  32'(unmask(out_data)), 32'h96);
        chk("t1_nops",   32'(out_nops),         32'd3);
        chk("t1_shares", 32'(out_data),         32'(exp_data));
        tick();
        chk("t1_drain_valid", 32'(out_valid), 32'd0);

        // Auto-termination at four operands, fifth starts a fresh accumulation
        drive(8'h01, 8'hA0, 1'b0);
        drive(8'h02, 8'h0B, 1'b0);
        drive(8'h04, 8'h3F, 1'b0);
        drive(8'h08, 8'hE1, 1'b0);
        chk("t2_valid", 32'(out_valid),        32'd1);
        chk("t2_value", 32'(unmask(out_data)), 32'h0F);
        chk("t2_nops",  32'(out_nops),         32'd4);
        drive(8'h10, 8'h6D, 1'b1);
        exp_data = share(8'h10, 8'h6D);
        chk("t2_next_valid", 32'(out_valid),        32'd1);
        chk("t2_next_value", 32'(unmask(out_data)), 32'h10);
        chk("t2_next_nops",  32'(out_nops),         32'd1);

        // Back-pressure in HOLD with a pending operand that must not be taken
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = share(8'h77, 8'h2B);
        in_last   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_in_ready",   32'(in_ready),  32'd0);
            chk("t3_hold_data",  32'(out_data),  32'(exp_data));
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t3_valid", 32'(out_valid),        32'd1);
        chk("t3_value", 32'(unmask(out_data)), 32'h77);
        chk("t3_nops",  32'(out_nops),         32'd1);
        chk("t3_shares", 32'(out_data),        32'(share(8'h77, 8'h2B)));
        tick();
        chk("t3_drain_valid", 32'(out_valid), 32'd0);

        // Back-to-back single-operand accumulations without a bubble
        drive(8'hC3, 8'h44, 1'b1);
        chk("t4_a_valid", 32'(out_valid),        32'd1);
        chk("t4_a_value", 32'(unmask(out_data)), 32'hC3);
        drive(8'h3C, 8'h99, 1'b1);
        in_valid = 1'b0;
        chk("t4_b_valid", 32'(out_valid),        32'd1);
        chk("t4_b_value", 32'(unmask(out_data)), 32'h3C);
        chk("t4_b_nops",  32'(out_nops),         32'd1);
        tick();

        // Reset in the middle of an accumulation discards it
        drive(8'h55, 8'h12, 1'b0);
        drive(8'h66, 8'h34, 1'b0);
        in_valid = 1'b0;
        chk("t5_partial_valid", 32'(out_valid), 32'd0);
        chk("t5_partial_nops",  32'(out_nops),  32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_data",  32'(out_data),  32'd0);
        chk("t5_rst_nops",  32'(out_nops),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t5_no_output", 32'(out_valid), 32'd0);
        drive(8'h11, 8'h7E, 1'b0);
        drive(8'h22, 8'h81, 1'b1);
        in_valid = 1'b0;
        chk("t5_valid", 32'(out_valid),        32'd1);
        chk("t5_value", 32'(unmask(out_data)), 32'h33);
        chk("t5_nops",  32'(out_nops),         32'd2);
        tick();

`ifdef MSK_XOR_ACC_REFRESH_EN
        // Refresh with all-ones randomness flips every share-0 bit
        rnd = 8'hFF;
        drive(8'h5A, 8'h96, 1'b1);
        in_valid = 1'b0;
        rnd = 8'h00;
        chk("t6_valid",  32'(out_valid),        32'd1);
        chk("t6_value",  32'(unmask(out_data)), 32'h5A);
        chk("t6_share0", 32'(share0(out_data)), 32'(~8'h96));
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
